// File: rtl/alu_key_sequencer.sv
// Debounced pushbutton sequencer for a 4-bit ALU feeding the 7-seg converter.
// Optional ALU_LIVE_PREVIEW_EN: aluout mirrors sw_data while loading operands.
module alu_key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic [3:0] sw_data,
  input  logic [1:0] sw_op,
  output logic [3:0] aluout,
  output logic       carry,
  output logic [1:0] phase
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t        state, state_d;
  logic          key_m, key_s;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          press;
  logic          accept;
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic [3:0]    out_q, out_d;
  logic          carry_q, carry_d;

  // Two-flop synchronizer; key_s is 1 while pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= ~key;
      key_s <= key_m;
    end
  end

  assign accept = (key_s != stable) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= accept && !stable;
      if (key_s == stable || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        stable <= ~stable;
      end
    end
  end

  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    unique case (state)
      LOAD_A: begin
        if (press) begin
          a_d     = sw_data;
          out_d   = sw_data;
          carry_d = 1'b0;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press) begin
          b_d     = sw_data;
          out_d   = sw_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = SHOW;
        unique case (sw_op)
          2'b00: {carry_d, out_d} = {1'b0, a_q} + {1'b0, b_q};
          2'b01: begin
            out_d   = a_q - b_q;
            carry_d = (a_q < b_q);
          end
          2'b10: begin
            out_d   = a_q & b_q;
            carry_d = 1'b0;
          end
          2'b11: begin
            out_d   = a_q | b_q;
            carry_d = 1'b0;
          end
        endcase
      end
      SHOW: begin
        if (press) begin
          state_d = LOAD_A;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state   <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign phase = state;

`ifdef ALU_LIVE_PREVIEW_EN
  logic loading;
  assign loading = (state == LOAD_A) || (state == LOAD_B);
  assign aluout  = loading ? sw_data : out_q;
  assign carry   = loading ? 1'b0 : carry_q;
`else
  assign aluout = out_q;
  assign carry  = carry_q;
`endif

endmodule

// File: tb/tb_alu_key_sequencer.sv
// Directed self-checking bench for alu_key_sequencer, DEBOUNCE_CYCLES=4.
module tb_alu_key_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b1;
  logic [3:0] sw_data = 4'h0;
  logic [1:0] sw_op = 2'b00;
  logic [3:0] aluout;
  logic       carry;
  logic [1:0] phase;

  int checks = 0;
  int failures = 0;

  alu_key_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .sw_data(sw_data),
    .sw_op(sw_op),
    .aluout(aluout),
    .carry(carry),
    .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    sw_data = d;
    key = 1'b0;
    repeat (10) step();
    key = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_reset();
    push(4'h5);
    key = 1'b0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (aluout !== 4'h0 || carry !== 1'b0 || phase !== 2'b00) begin
      failures++;
      $display("FAIL reset_async: out=%h c=%b ph=%b need 0 0 00",
               aluout, carry, phase);
    end
    key = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) step();
    checks++;
    if (phase !== 2'b00 || aluout !== 4'h0) begin
      failures++;
      $display("FAIL reset_nopress: ph=%b out=%h need 00 0", phase, aluout);
    end
  endtask

  task automatic test_debounce();
    int np;
    np = 0;
    for (int g = 0; g < 5; g++) begin
      key = 1'b0;
      repeat (3) begin
        step();
        if (dut.press) np++;
      end
      key = 1'b1;
      repeat (3) begin
        step();
        if (dut.press) np++;
      end
    end
    repeat (6) begin
      step();
      if (dut.press) np++;
    end
    checks++;
    if (np !== 0 || phase !== 2'b00) begin
      failures++;
      $display("FAIL glitch: presses=%0d ph=%b need 0 00", np, phase);
    end
    sw_data = 4'h3;
    key = 1'b0;
    np = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (dut.press) begin
        np++;
        checks++;
        if (n !== 6) begin
          failures++;
          $display("FAIL press_latency: at=%0d need 6", n);
        end
      end
      if (n == 6) begin
        checks++;
        if (phase !== 2'b00) begin
          failures++;
          $display("FAIL phase_pre: ph=%b need 00", phase);
        end
      end
      if (n == 7) begin
        checks++;
        if (phase !== 2'b01 || aluout !== 4'h3) begin
          failures++;
          $display("FAIL phase_post: ph=%b out=%h need 01 3", phase, aluout);
        end
      end
    end
    checks++;
    if (np !== 1) begin
      failures++;
      $display("FAIL press_count: got=%0d need 1", np);
    end
    key = 1'b1;
    repeat (10) step();
    push(4'h0);
    push(4'h0);
    checks++;
    if (phase !== 2'b00) begin
      failures++;
      $display("FAIL debounce_wrap: ph=%b need 00", phase);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic [3:0] eo,
                        input logic ec, input string name);
    sw_op = op;
    push(a);
    checks++;
    if (phase !== 2'b01 || aluout !== a || carry !== 1'b0) begin
      failures++;
      $display("FAIL %s_loada: ph=%b out=%h c=%b need 01 %h 0",
               name, phase, aluout, carry, a);
    end
    push(b);
    sw_data = 4'h0;
    #1;
    checks++;
    if (phase !== 2'b11 || aluout !== eo || carry !== ec) begin
      failures++;
      $display("FAIL %s_show: ph=%b out=%h c=%b need 11 %h %b",
               name, phase, aluout, carry, eo, ec);
    end
    push(4'h0);
  endtask

  task automatic test_ops();
    run_op(4'h9, 4'h8, 2'b00, 4'h1, 1'b1, "add");
    run_op(4'h3, 4'h5, 2'b01, 4'hE, 1'b1, "sub_borrow");
    run_op(4'h7, 4'h2, 2'b01, 4'h5, 1'b0, "sub");
    run_op(4'hC, 4'hA, 2'b10, 4'h8, 1'b0, "and");
    run_op(4'hC, 4'hA, 2'b11, 4'hE, 1'b0, "or");
    run_op(4'hF, 4'h1, 2'b00, 4'h0, 1'b1, "add_wrap");
  endtask

  task automatic test_wrap();
    sw_op = 2'b00;
    push(4'h2);
    push(4'h3);
    push(4'hA);
    checks++;
`ifdef ALU_LIVE_PREVIEW_EN
    if (phase !== 2'b00 || aluout !== 4'hA) begin
`else
    if (phase !== 2'b00 || aluout !== 4'h5) begin
`endif
      failures++;
      $display("FAIL wrap_hold: ph=%b out=%h", phase, aluout);
    end
    push(4'h6);
    checks++;
    if (phase !== 2'b01 || aluout !== 4'h6) begin
      failures++;
      $display("FAIL wrap_next: ph=%b out=%h need 01 6", phase, aluout);
    end
    push(4'h1);
    push(4'h0);
  endtask

  task automatic test_preview();
    logic [3:0] held;
    held = aluout;
    for (int v = 0; v < 16; v++) begin
      sw_data = 4'(v);
      #1;
      checks++;
`ifdef ALU_LIVE_PREVIEW_EN
      if (aluout !== 4'(v) || carry !== 1'b0) begin
        failures++;
        $display("FAIL preview: out=%h need %h", aluout, 4'(v));
      end
`else
      if (aluout !== held) begin
        failures++;
        $display("FAIL no_preview: out=%h need %h", aluout, held);
      end
`endif
    end
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++;
    if (aluout !== 4'h0 || carry !== 1'b0 || phase !== 2'b00) begin
      failures++;
      $display("FAIL reset_init: out=%h c=%b ph=%b", aluout, carry, phase);
    end
    test_reset();
    test_debounce();
    test_ops();
    test_wrap();
    test_preview();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_key_sequencer.md
Name: alu_key_sequencer

Overview:
- Upstream stage of the hex-to-7-segment output converter on the interview board.
- Sequences a pushbutton-driven 4-bit ALU: latches operand A, then operand B, from the slide switches, executes the selected operation and holds the result.
- Result drives the converter's 4-bit aluout input. Carry/borrow drives a discrete LED.

Parameters:
DEBOUNCE_CYCLES, 50000, clock cycles the synchronized key must hold a new level before that level is accepted; legal range 2..2^20.

Ports:
clk  input  1  system clock (50 MHz board clock)
rst  input  1  asynchronous, active-high reset
key  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk
sw_data  input  4  operand value from slide switches
sw_op  input  2  operation select: 00 add, 01 sub, 10 and, 11 or
aluout  output  4  value to the 7-segment converter
carry  output  1  add carry-out / sub borrow flag
phase  output  2  current FSM state code, for status LEDs

Behaviour:
- Reset: one clock, asynchronous active-high reset; all flops clear on rst high without waiting for clk.
- Reset values: aluout=0, carry=0, phase=00 (LOAD_A), operand regs A=B=0, debounce counter=0, stable level=released.
- Input sync: key inverted and passed through 2 flops to give key_s (1 = pressed).
- Debounce: counter clears whenever key_s equals the stable level. Otherwise it increments.
- When counter == DEBOUNCE_CYCLES-1 and key_s still differs: stable level toggles and counter clears.
- press: one-cycle pulse on a stable released->pressed transition. Release transitions produce no pulse.
- Press latency: counted from the first raw-key edge held low, press asserts DEBOUNCE_CYCLES+2 cycles later.
- Glitch rule: bounces shorter than DEBOUNCE_CYCLES never produce press.
- A held key produces exactly one press; a new press requires a stable release first.
- FSM states (phase code):
  - LOAD_A (00): on press, A<=sw_data, aluout<=sw_data, carry<=0, go to LOAD_B.
  - LOAD_B (01): on press, B<=sw_data, aluout<=sw_data, go to EXEC.
  - EXEC (10): unconditional single cycle. Computes using sw_op sampled this cycle, then goes to SHOW.
    - add: {carry,aluout} <= A+B, 5-bit result.
    - sub: aluout <= (A-B) mod 16, carry <= (A<B).
    - and/or: bitwise result, carry <= 0.
  - SHOW (11): hold aluout and carry. On press go to LOAD_A; aluout and carry hold until the next LOAD_A press.
- Without a press, every state holds all registers.
- sw_data and sw_op are treated as quasi-static and sampled only at the stated events.
- Reset mid-debounce or mid-sequence discards the partial press and operands and returns to LOAD_A.
- press arriving in the EXEC cycle is impossible: the 2-cycle minimum spacing is guaranteed by the debounce.

Optional Feature:
- Macro: ALU_LIVE_PREVIEW_EN.
- Defined: in LOAD_A and LOAD_B, aluout combinationally mirrors sw_data (live operand preview) and carry=0. EXEC/SHOW unchanged.
- Undefined: aluout is purely registered exactly as in Behaviour. No combinational path from sw_data to aluout.

Test Plan:
- Reset: assert rst mid-run with key held and counter nonzero. Required: aluout=0, carry=0, phase=00 immediately; no press after release of rst until a fresh debounced press.
- Debounce (DEBOUNCE_CYCLES=4): key low for 3 cycles then high, repeated 5 times. Required: no press and phase stays 00. Then key low for 10 cycles: exactly one press, 6 cycles after the falling edge.
- Add with carry: A=9, B=8, sw_op=00. Required in SHOW: aluout=4'h1, carry=1, phase=11.
- Sub with borrow: A=3, B=5, sw_op=01. Required: aluout=4'hE, carry=1. Then A=7, B=2: aluout=5, carry=0.
- Logic ops: A=4'b1100, B=4'b1010. Required: and gives 4'b1000, or gives 4'b1110, carry=0 in both.
- Wrap of sequence: press in SHOW. Required: phase=00 with aluout still showing the result. Next press with sw_data=6 gives aluout=6, phase=01.
- Optional feature: with ALU_LIVE_PREVIEW_EN defined, sweep sw_data 0..F in LOAD_A; aluout must track it in the same cycle.
